mor1kx_ctrl_wb_cappuccino: RTL and testbench

//  Control-to-writeback stage, directly downstream of the execute/ctrl stage registers.
//  - Selects the RF writeback data from the ALU result, load data or mfspr data.
//  - Aligns and extends load data, then registers a single RF write per instruction.
//  - Holds the architectural SR F/CY/OV bits.
//  - A 3-state FSM tracks load/mfspr completion so a result that arrives while ctrl is held is written exactly once.

---
 rtl/mor1kx_ctrl_wb_cappuccino.sv | 113 +++++++++++
 tb/tb_mor1kx_ctrl_wb_cappuccino.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_ctrl_wb_cappuccino.sv
// mor1kx_ctrl_wb_cappuccino: ctrl-to-writeback stage with load formatting, SR bits and bus-completion FSM.
// Optional operand bypass compare is built when MOR1KX_WB_BYPASS_EN is defined.
module mor1kx_ctrl_wb_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            padv_ctrl_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic                            ctrl_op_lsu_load_i,
  input  logic                            ctrl_op_mfspr_i,
  input  logic [1:0]                      ctrl_lsu_adr_i,
  input  logic [1:0]                      ctrl_lsu_length_i,
  input  logic                            ctrl_lsu_zext_i,
  input  logic                            lsu_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_ldat_i,
  input  logic                            ctrl_mfspr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_i,
  input  logic                            ctrl_flag_set_i,
  input  logic                            ctrl_flag_clear_i,
  input  logic                            ctrl_carry_set_i,
  input  logic                            ctrl_carry_clear_i,
  input  logic                            ctrl_overflow_set_i,
  input  logic                            ctrl_overflow_clear_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfb_adr_i,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
  output logic                            flag_o,
  output logic                            carry_o,
  output logic                            overflow_o,
  output logic                            wb_bypass_a_o,
  output logic                            wb_bypass_b_o,
  output logic                            ctrl_bus_done_o
);
  localparam int W = OPTION_OPERAND_WIDTH;
  if (W != 32) begin : g_width_check
    $error("mor1kx_ctrl_wb_cappuccino: only OPTION_OPERAND_WIDTH=32 is supported");
  end
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state, next_state;
  logic         is_bus, ack, fire, wb_en;
  logic [7:0]   byte_dat;
  logic [15:0]  half_dat;
  logic [W-1:0] load_dat, wb_dat;
  assign is_bus = ctrl_op_lsu_load_i | ctrl_op_mfspr_i;
  assign ack    = ctrl_op_lsu_load_i ? lsu_valid_i : ctrl_op_mfspr_i & ctrl_mfspr_ack_i;
  // A result already captured in HOLD was written at ack time, so HOLD never fires again.
  assign fire   = is_bus ? ack & (state != HOLD) : padv_ctrl_i;
  assign wb_en  = ctrl_rf_wb_i & ~pipeline_flush_i & fire;
  always_comb begin
    byte_dat = ctrl_lsu_adr_i == 2'd0 ? lsu_ldat_i[31:24] :
               ctrl_lsu_adr_i == 2'd1 ? lsu_ldat_i[23:16] :
               ctrl_lsu_adr_i == 2'd2 ? lsu_ldat_i[15:8]  : lsu_ldat_i[7:0];
    half_dat = ctrl_lsu_adr_i[1] ? lsu_ldat_i[15:0] : lsu_ldat_i[31:16];
    load_dat = ctrl_lsu_length_i == 2'b00 ? {{(W-8){~ctrl_lsu_zext_i & byte_dat[7]}}, byte_dat} :
               ctrl_lsu_length_i == 2'b01 ? {{(W-16){~ctrl_lsu_zext_i & half_dat[15]}}, half_dat} :
               lsu_ldat_i;
    wb_dat   = ctrl_op_lsu_load_i ? load_dat : ctrl_op_mfspr_i ? mfspr_dat_i : ctrl_alu_result_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  always_comb begin
    next_state = state;
    if (pipeline_flush_i)
      next_state = IDLE;
    else if (state == HOLD)
      next_state = padv_ctrl_i ? IDLE : HOLD;
    else if (ack)
      next_state = padv_ctrl_i ? IDLE : HOLD;
    else if (state == IDLE && is_bus && ctrl_rf_wb_i)
      next_state = WAIT;
  end
  always_comb ctrl_bus_done_o = state == HOLD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_rf_wb_o   <= 1'b0;
      wb_rfd_adr_o <= '0;
      wb_result_o  <= '0;
    end else begin
      wb_rf_wb_o <= wb_en;
      if (wb_en) begin
        wb_rfd_adr_o <= ctrl_rfd_adr_i;
        wb_result_o  <= wb_dat;
      end
    end
  // Set takes precedence over clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag_o     <= 1'b0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (padv_ctrl_i & ~pipeline_flush_i) begin
      flag_o     <= ctrl_flag_set_i     | (flag_o     & ~ctrl_flag_clear_i);
      carry_o    <= ctrl_carry_set_i    | (carry_o    & ~ctrl_carry_clear_i);
      overflow_o <= ctrl_overflow_set_i | (overflow_o & ~ctrl_overflow_clear_i);
    end
`ifdef MOR1KX_WB_BYPASS_EN
  assign wb_bypass_a_o = wb_rf_wb_o & (wb_rfd_adr_o == decode_rfa_adr_i);
  assign wb_bypass_b_o = wb_rf_wb_o & (wb_rfd_adr_o == decode_rfb_adr_i);
`else
  logic unused_decode;
  assign unused_decode = ^{decode_rfa_adr_i, decode_rfb_adr_i};
  assign wb_bypass_a_o = 1'b0;
  assign wb_bypass_b_o = 1'b0;
`endif
endmodule

// File: tb/tb_mor1kx_ctrl_wb_cappuccino.sv
// tb_mor1kx_ctrl_wb_cappuccino: directed and random checks against a behavioural writeback model.
module tb_mor1kx_ctrl_wb_cappuccino;
  logic clk = 1'b0, rst_n = 1'b0;
  logic padv, flush, rf_wb, is_load, is_mfspr, zext, valid, mack;
  logic fs, fc, cs, cc, os, oc;
  logic [4:0] rfd, rfa, rfb;
  logic [1:0] ladr, llen;
  logic [31:0] alu, ldat, sdat;
  logic we_o, flag, carry, ovf, byp_a, byp_b, done;
  logic [4:0] adr_o;
  logic [31:0] res_o;
  int errors = 0, checks = 0;
  logic m_we, m_f, m_c, m_o, m_held;
  logic [4:0] m_adr;
  logic [31:0] m_res;

  mor1kx_ctrl_wb_cappuccino dut (
    .clk(clk), .rst_n(rst_n), .padv_ctrl_i(padv), .pipeline_flush_i(flush),
    .ctrl_rf_wb_i(rf_wb), .ctrl_rfd_adr_i(rfd), .ctrl_alu_result_i(alu),
    .ctrl_op_lsu_load_i(is_load), .ctrl_op_mfspr_i(is_mfspr), .ctrl_lsu_adr_i(ladr),
    .ctrl_lsu_length_i(llen), .ctrl_lsu_zext_i(zext), .lsu_valid_i(valid), .lsu_ldat_i(ldat),
    .ctrl_mfspr_ack_i(mack), .mfspr_dat_i(sdat),
    .ctrl_flag_set_i(fs), .ctrl_flag_clear_i(fc), .ctrl_carry_set_i(cs),
    .ctrl_carry_clear_i(cc), .ctrl_overflow_set_i(os), .ctrl_overflow_clear_i(oc),
    .decode_rfa_adr_i(rfa), .decode_rfb_adr_i(rfb),
    .wb_rf_wb_o(we_o), .wb_rfd_adr_o(adr_o), .wb_result_o(res_o),
    .flag_o(flag), .carry_o(carry), .overflow_o(ovf),
    .wb_bypass_a_o(byp_a), .wb_bypass_b_o(byp_b), .ctrl_bus_done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmt(logic [31:0] d, logic [1:0] a, logic [1:0] len, logic z);
    logic [31:0] v;
    int sh;
    if (len == 2'b00) begin
      sh = 8 * (3 - int'(a));
      v = (d >> sh) & 32'hff;
      if (!z && v[7]) v = v | 32'hffff_ff00;
    end else if (len == 2'b01) begin
      sh = a[1] ? 0 : 16;
      v = (d >> sh) & 32'hffff;
      if (!z && v[15]) v = v | 32'hffff_0000;
    end else v = d;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {padv, flush, rf_wb, is_load, is_mfspr, zext, valid, mack} = '0;
    {fs, fc, cs, cc, os, oc} = '0;
    rfd = 0; rfa = 0; rfb = 0; ladr = 0; llen = 0; alu = 0; ldat = 0; sdat = 0;
  endtask

  task automatic model_reset();
    m_we = 0; m_adr = 0; m_res = 0; m_f = 0; m_c = 0; m_o = 0; m_held = 0;
  endtask

  // One clock of the reference: a bus result is written on its first ack, and a captured
  // result stays pending until ctrl advances or is flushed.
  task automatic model_step();
    logic bus, ack, fire;
    bus  = is_load | is_mfspr;
    ack  = is_load ? valid : (is_mfspr & mack);
    fire = bus ? (ack && !m_held) : padv;
    m_we = rf_wb && !flush && fire;
    if (m_we) begin
      m_adr = rfd;
      m_res = is_load ? fmt(ldat, ladr, llen, zext) : is_mfspr ? sdat : alu;
    end
    if (flush) m_held = 0;
    else if (m_held) m_held = !padv;
    else m_held = ack && !padv;
    if (padv && !flush) begin
      m_f = fs ? 1'b1 : fc ? 1'b0 : m_f;
      m_c = cs ? 1'b1 : cc ? 1'b0 : m_c;
      m_o = os ? 1'b1 : oc ? 1'b0 : m_o;
    end
  endtask

  task automatic check_all();
    logic ea, eb;
`ifdef MOR1KX_WB_BYPASS_EN
    ea = m_we && (m_adr == rfa);
    eb = m_we && (m_adr == rfb);
`else
    ea = 0; eb = 0;
`endif
    chk("wb_rf_wb", we_o, m_we);
    chk("wb_rfd_adr", adr_o, m_adr);
    chk("wb_result", res_o, m_res);
    chk("flag", flag, m_f);
    chk("carry", carry, m_c);
    chk("overflow", ovf, m_o);
    chk("bus_done", done, m_held);
    chk("bypass_a", byp_a, ea);
    chk("bypass_b", byp_b, eb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #12;
    chk("reset_we", we_o, 0);
    chk("reset_result", res_o, 0);
    chk("reset_done", done, 0);
    check_all();
    rst_n = 1;
    // byte load, sign-extended, completes with advance
    rf_wb = 1; is_load = 1; ladr = 2; llen = 2'b00; zext = 0; ldat = 32'h1122_8344;
    valid = 1; padv = 1; rfd = 3;
    tick();
    chk("ld_byte_we", we_o, 1);
    chk("ld_byte_res", res_o, 32'hFFFF_FF83);
    // half load arrives while ctrl is stalled
    ladr = 2; llen = 2'b01; zext = 1; ldat = 32'h1234_ABCD; valid = 1; padv = 0; rfd = 7;
    tick();
    chk("ld_half_we", we_o, 1);
    chk("ld_half_res", res_o, 32'h0000_ABCD);
    chk("ld_half_done", done, 1);
    valid = 0;
    tick();
    chk("hold_no_write", we_o, 0);
    chk("hold_done", done, 1);
    valid = 1; ldat = 32'hDEAD_BEEF;
    tick();
    chk("hold_second_ack", we_o, 0);
    chk("hold_res_kept", res_o, 32'h0000_ABCD);
    valid = 0; padv = 1;
    tick();
    chk("hold_release_done", done, 0);
    chk("hold_release_we", we_o, 0);
    // mfspr ack cancelled by flush
    clear_inputs();
    is_mfspr = 1; rf_wb = 1; mack = 1; flush = 1; sdat = 32'h5555_AAAA; rfd = 4;
    tick();
    chk("mfspr_flush_we", we_o, 0);
    chk("mfspr_flush_done", done, 0);
    // SR set/clear priority and flush suppression
    clear_inputs();
    padv = 1; fs = 1; fc = 1;
    tick();
    chk("flag_set_wins", flag, 1);
    fs = 0; fc = 0; cs = 1; flush = 1;
    tick();
    chk("carry_flush", carry, 0);
    // ALU write to r5 against decode operands
    clear_inputs();
    rf_wb = 1; padv = 1; rfd = 5; alu = 32'h0BAD_F00D; rfa = 3; rfb = 5;
    tick();
    chk("alu_we", we_o, 1);
`ifdef MOR1KX_WB_BYPASS_EN
    chk("bypass_b_hit", byp_b, 1);
`else
    chk("bypass_b_off", byp_b, 0);
`endif
    chk("bypass_a_miss", byp_a, 0);
    // reset asserted while a load is waiting
    clear_inputs();
    padv = 1; fs = 1;
    tick();
    rf_wb = 1; is_load = 1; llen = 2'b10; rfd = 9; padv = 0; fs = 0;
    tick();
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_flag", flag, 0);
    check_all();
    #2 rst_n = 1;
    valid = 1; padv = 1; ldat = 32'hCAFE_1234;
    tick();
    chk("post_rst_we", we_o, 1);
    chk("post_rst_res", res_o, 32'hCAFE_1234);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 5);
      is_load = op < 2; is_mfspr = op == 2;
      rf_wb = $urandom_range(0, 3) != 0;
      padv = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 9) == 0;
      valid = $urandom_range(0, 2) == 0; mack = $urandom_range(0, 2) == 0;
      rfd = 5'($urandom_range(0, 7)); rfa = 5'($urandom_range(0, 7)); rfb = 5'($urandom_range(0, 7));
      ladr = 2'($urandom); llen = 2'($urandom); zext = 1'($urandom);
      alu = $urandom; ldat = $urandom; sdat = $urandom;
      {fs, fc, cs, cc, os, oc} = 6'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
